// File: rtl/ds_pkg.sv
// rtl/ds_pkg.sv - shared constants and FIFO entry type for the downsampled frame packer
package ds_pkg;

  localparam int DS_IMG_W           = 400;
  localparam int DS_IMG_H           = 300;
  localparam int DS_WORDS_PER_FRAME = DS_IMG_W * DS_IMG_H / 4;
  localparam int DS_WADDR_W         = 15;

  typedef struct packed {
    logic [DS_WADDR_W:0] addr;
    logic [31:0]         data;
  } ds_fifo_entry_t;

endpackage

// File: rtl/sync_word_fifo.sv
// rtl/sync_word_fifo.sv - first-word fall-through synchronous FIFO with full/empty flags
module sync_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_en = pop && !empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    wr_en = push && (!full || rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ds_frame_packer.sv
// rtl/ds_frame_packer.sv - packs 4 downsampled pixels per word, addresses them and ping-pongs buffers
module ds_frame_packer
  import ds_pkg::*;
#(
  parameter int IMG_W      = DS_IMG_W,
  parameter int IMG_H      = DS_IMG_H,
  parameter int WADDR_W    = DS_WADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  input  logic               in_blank,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [WADDR_W:0]   out_addr,
  output logic               frame_done,
  output logic               rd_buffer,
  output logic               overflow
);

  localparam int                 WORDS    = IMG_W * IMG_H / 4;
  localparam int                 EW       = WADDR_W + 1 + 32;
  localparam logic [WADDR_W-1:0] LAST_IDX = WADDR_W'(WORDS - 1);

  logic [1:0]         lane_q, lane_d;
  logic [23:0]        pack_q, pack_d;
  logic [WADDR_W-1:0] word_idx_q, word_idx_d;
  logic               wbuf_q, wbuf_d;
  logic               rd_buffer_q, rd_buffer_d;
  logic               frame_done_q, frame_done_d;
  logic               overflow_q, overflow_d;
  logic               accept, push, pop, fifo_full, fifo_empty;
  logic [EW-1:0]      push_entry, pop_entry;

  always_comb begin
    accept       = in_valid && !in_blank;
    push         = accept && (lane_q == 2'd3);
    pop          = !fifo_empty && out_ready;
    // Lanes 0..2 live in the pack register; lane 3 joins straight from the input.
    push_entry   = {wbuf_q, word_idx_q, in_data, pack_q};
    lane_d       = lane_q;
    pack_d       = pack_q;
    word_idx_d   = word_idx_q;
    wbuf_d       = wbuf_q;
    rd_buffer_d  = rd_buffer_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    if (accept) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    pack_d[7:0]   = in_data;
        2'd1:    pack_d[15:8]  = in_data;
        2'd2:    pack_d[23:16] = in_data;
        default: pack_d        = pack_q;
      endcase
    end
    // Dropped words still consume an index so later addresses stay aligned.
    if (push) begin
      if (fifo_full && !pop) overflow_d = 1'b1;
      if (word_idx_q == LAST_IDX) begin
        word_idx_d   = '0;
        frame_done_d = 1'b1;
        rd_buffer_d  = wbuf_q;
        wbuf_d       = !wbuf_q;
      end else begin
        word_idx_d = word_idx_q + WADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q       <= '0;
      pack_q       <= '0;
      word_idx_q   <= '0;
      wbuf_q       <= 1'b0;
      rd_buffer_q  <= 1'b1;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      word_idx_q   <= word_idx_d;
      wbuf_q       <= wbuf_d;
      rd_buffer_q  <= rd_buffer_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  sync_word_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = pop_entry[31:0];
  assign out_addr   = pop_entry[EW-1:32];
  assign frame_done = frame_done_q;
  assign rd_buffer  = rd_buffer_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ds_frame_packer.sv
// tb/tb_ds_frame_packer.sv - self-checking bench for ds_frame_packer
module tb_ds_frame_packer;

  localparam int TW  = 40;
  localparam int TH  = 30;
  localparam int TWA = 9;
  localparam int TD  = 4;
  localparam int F   = TW * TH / 4;

  typedef struct {
    logic [TWA:0] addr;
    logic [31:0]  data;
  } exp_t;

  typedef struct {
    logic       blank;
    logic [7:0] data;
    logic       exp_valid;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_blank = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic [TWA:0]  out_addr;
  logic          frame_done;
  logic          rd_buffer;
  logic          overflow;

  int            n_vec = 0;
  int            n_err = 0;
  int            fd_count = 0;
  logic [TWA:0]  last_addr = '0;
  logic          ready_cmd = 1'b1;
  logic          rand_mode = 1'b0;
  logic          sb_skip = 1'b0;
  exp_t          sb[$];
  vec_t          vec[24];
  logic [1:0]    m_lane = '0;
  logic [31:0]   m_pack = '0;
  logic [TWA-1:0] m_idx = '0;
  logic          m_buf = 1'b0;
  logic [31:0]   held;

  ds_frame_packer #(
    .IMG_W      (TW),
    .IMG_H      (TH),
    .WADDR_W    (TWA),
    .FIFO_DEPTH (TD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_blank   (in_blank),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .frame_done (frame_done),
    .rd_buffer  (rd_buffer),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_cmd;
  end

  // Scoreboard monitor, sampled mid-cycle before the next active edge.
  always @(negedge clock) begin
    #4;
    if (frame_done) fd_count++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got word 0x%08h at 0x%0h, expected none", out_data, out_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", 64'(out_data), 64'(e.data));
        check("sb_addr", 64'(out_addr), 64'(e.addr));
      end
      last_addr = out_addr;
    end
  end

  task automatic model_reset();
    sb.delete();
    m_lane   = '0;
    m_pack   = '0;
    m_idx    = '0;
    m_buf    = 1'b0;
    fd_count = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_data"}, 64'(out_data), 64'(0));
    check({tag, "_out_addr"}, 64'(out_addr), 64'(0));
    check({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    check({tag, "_rd_buffer"}, 64'(rd_buffer), 64'(1));
    check({tag, "_overflow"}, 64'(overflow), 64'(0));
  endtask

  task automatic drive_pixel(input logic blank, input logic [7:0] d, input logic chk, input logic expv);
    @(negedge clock);
    in_valid = 1'b1;
    in_blank = blank;
    in_data  = d;
    if (!blank) begin
      m_pack[m_lane*8 +: 8] = d;
      if (m_lane == 2'd3) begin
        if (!sb_skip) sb.push_back('{addr: {m_buf, m_idx}, data: m_pack});
        if (m_idx == TWA'(F - 1)) begin
          m_idx = '0;
          m_buf = !m_buf;
        end else begin
          m_idx = m_idx + TWA'(1);
        end
      end
      m_lane = m_lane + 2'd1;
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_blank = 1'b0;
    in_data  = 8'h00;
    if (chk) begin
      #1;
      check("valid_latency", 64'(out_valid), 64'(expv));
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    check({tag, "_drained"}, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vec[i] = '{1'b0, 8'(i + 1), (i % 4) == 3};
    for (int j = 0; j < 8; j++) begin
      vec[8 + 2*j] = '{1'b1, 8'h03, 1'b0};
      vec[9 + 2*j] = '{1'b0, 8'(8'h11 + j), (j % 4) == 3};
    end

    // Basic packing, latency and blank-strobe immunity.
    ready_cmd = 1'b1;
    do_reset();
    check_reset_state("reset");
    for (int i = 0; i < 24; i++) drive_pixel(vec[i].blank, vec[i].data, 1'b1, vec[i].exp_valid);
    wait_drain("vec");
    check("vec_last_addr", 64'(last_addr), 64'(3));

    // Downstream stall: 4 words held, 5th dropped, index keeps counting.
    ready_cmd = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_pixel(1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
      if (i == 3) begin
        #1;
        held = out_data;
      end
    end
    #1;
    check("stall_no_ovf_yet", 64'(overflow), 64'(0));
    sb_skip = 1'b1;
    for (int i = 16; i < 20; i++) drive_pixel(1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
    sb_skip = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("stall_valid", 64'(out_valid), 64'(1));
    check("stall_stable", 64'(out_data), 64'(held));
    check("stall_head", 64'(out_data), 64'(32'h43424140));
    check("stall_ovf", 64'(overflow), 64'(1));
    ready_cmd = 1'b1;
    wait_drain("stall");
    for (int i = 0; i < 4; i++) drive_pixel(1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
    wait_drain("post_stall");
    check("post_stall_addr", 64'(last_addr), 64'(5));
    check("ovf_sticky", 64'(overflow), 64'(1));

    // Reset in the middle of a word.
    do_reset();
    for (int i = 0; i < 6; i++) drive_pixel(1'b0, 8'(8'h90 + i), 1'b0, 1'b0);
    do_reset();
    check_reset_state("midreset");
    drive_pixel(1'b0, 8'hAA, 1'b0, 1'b0);
    drive_pixel(1'b0, 8'hBB, 1'b0, 1'b0);
    drive_pixel(1'b0, 8'hCC, 1'b0, 1'b0);
    drive_pixel(1'b0, 8'hDD, 1'b0, 1'b0);
    #1;
    check("midreset_word", 64'(out_data), 64'(32'hDDCCBBAA));
    check("midreset_addr", 64'(out_addr), 64'(0));
    wait_drain("midreset");
    check("midreset_ovf", 64'(overflow), 64'(0));
    check("midreset_rdbuf", 64'(rd_buffer), 64'(1));

    // One full frame, then the first word of the next buffer.
    do_reset();
    for (int i = 0; i < F*4; i++) drive_pixel(1'b0, 8'(i), 1'b0, 1'b0);
    wait_drain("frame");
    check("frame_last_addr", 64'(last_addr), 64'({1'b0, TWA'(F - 1)}));
    check("frame_done_count", 64'(fd_count), 64'(1));
    check("frame_rdbuf", 64'(rd_buffer), 64'(0));
    for (int i = 0; i < 4; i++) drive_pixel(1'b0, 8'(i), 1'b0, 1'b0);
    wait_drain("frame_next");
    check("frame_next_addr", 64'(last_addr), 64'({1'b1, TWA'(0)}));

    // Two frames at full input rate against a random-ready sink.
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 2*F*4; i++) begin
      if (i % 37 == 5) drive_pixel(1'b1, 8'($urandom), 1'b0, 1'b0);
      drive_pixel(1'b0, 8'($urandom), 1'b0, 1'b0);
    end
    rand_mode = 1'b0;
    wait_drain("rand");
    check("rand_ovf", 64'(overflow), 64'(0));
    check("rand_fd_count", 64'(fd_count), 64'(2));
    check("rand_rdbuf", 64'(rd_buffer), 64'(1));
    check("rand_last_addr", 64'(last_addr), 64'({1'b1, TWA'(F - 1)}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ds_frame_packer.md
Name: ds_frame_packer

Overview:
- Consumes the 2:1 downsampled pixel stream (400x300 active pixels, 8-bit greyscale) produced by the downsampling stage.
- Packs four consecutive active pixels into one 32-bit word and attaches a frame-buffer word address.
- Buffers the words and presents them on a valid/ready port to the frame-buffer write arbiter.
- Alternates (ping-pong) between two frame buffers so the feature detector can read one complete frame while the next one is written.

Parameters:
- IMG_W, 400, active pixels per downsampled line; must be a multiple of 4.
- IMG_H, 300, active lines per downsampled frame.
- WADDR_W, 15, word-address bits per buffer; must satisfy 2^WADDR_W >= IMG_W*IMG_H/4.
- FIFO_DEPTH, 4, depth of the output word FIFO; power of 2, minimum 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  pixel strobe from the downsampler (its validout); high for active and blanking samples.
- in_data  in  8  pixel value (its dataout).
- in_blank  in  1  blanking qualifier (its blankingregion); a strobe with in_blank=1 carries no pixel.
- out_valid  out  1  out_data/out_addr hold a word.
- out_ready  in  1  downstream accepts the word this cycle.
- out_data  out  32  packed pixels; the first pixel in time is in [7:0], the last in [31:24].
- out_addr  out  WADDR_W+1  [WADDR_W] = buffer select; [WADDR_W-1:0] = word index within the frame.
- frame_done  out  1  one-cycle pulse when the last word of a frame enters the FIFO.
- rd_buffer  out  1  buffer holding the most recent complete frame.
- overflow  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset: all counters 0, FIFO empty, out_valid=0, out_data=0, out_addr=0, frame_done=0, rd_buffer=1, write buffer=0, overflow=0. Reset mid-frame discards any partial word and FIFO contents.
- Pixel accept condition: in_valid && !in_blank. No other qualifier exists, because the input has no backpressure.
- Lane counter (0..3), 2-bit: each accepted pixel is written into byte lane[lane] of the pack register.
- A word is formed on the accept with lane==3. Word = {pixel3, pixel2, pixel1, pixel0}. Its address = {wbuf, word_idx}.
- Word push: the word is pushed into the FIFO on the cycle after that accept (1-cycle pack latency). word_idx then increments.
- Frame end: when word_idx == IMG_W*IMG_H/4 - 1 (29999 with default parameters) is pushed:
  - frame_done pulses that cycle;
  - word_idx wraps to 0;
  - rd_buffer <= wbuf and wbuf toggles.
- Lines are tracked only implicitly by the word count. No line counter is needed, because IMG_W is a multiple of 4.
- FIFO: first-word fall-through. out_valid = !empty. Pop on out_valid && out_ready. Data and address are stable while out_valid && !out_ready.
- Full boundary:
  - Push and pop in the same cycle are both performed when the FIFO is full.
  - A push to a full FIFO with no pop drops the word and sets overflow=1.
  - After a drop, word_idx still increments so later addresses stay correct.
- Simultaneous events: an accept with lane==3 while the previous word is being pushed is legal. The push register is separate from the pack register.
- Blanking strobes never change the lane, word_idx or buffer state.
- The input strobe rate is at most one pixel every 2 cycles, so the sustained rate is one word per 8 cycles. FIFO_DEPTH=4 absorbs downstream stalls of up to about 32 cycles.
- Widths: lane 2 bits, word_idx WADDR_W bits. The frame-end comparison is an exact equality against the computed constant.

Decomposition:
- Package ds_pkg:
  - constants DS_IMG_W=400, DS_IMG_H=300;
  - DS_WORDS_PER_FRAME = DS_IMG_W*DS_IMG_H/4;
  - DS_WADDR_W=15;
  - a packed struct for the FIFO entry {addr[WADDR_W:0], data[31:0]}.
- One sub-module, sync_word_fifo: parameterised width and depth, first-word fall-through, exposing full/empty. This module instantiates it and owns packing, addressing and buffer control.

Test Plan:
- Reset, then 8 accepted pixels 0x01..0x08 with out_ready=1 -> word 0x04030201 at addr 0, then 0x08070605 at addr 1. Each out_valid rises 1 cycle after the 4th pixel's accept cycle.
- Interleave in_valid=1,in_blank=1 strobes with data 0x03 between active pixels -> packed words contain no 0x03 bytes, and the lane sequence is unaffected.
- Full frame of 120000 pixels, value = index mod 256, out_ready=1:
  - last word at addr 29999 with buffer bit 0;
  - frame_done pulses once and rd_buffer becomes 0;
  - the next frame's first word is at addr {1, 0}.
- Hold out_ready=0 for 5 words with FIFO_DEPTH=4:
  - the first 4 words are retained in order and out_data stays stable;
  - the 5th word is dropped and overflow=1 stays set;
  - when ready returns, the next word carries address 5.
- Assert reset after 6 pixels mid-frame, then feed 4 pixels 0xAA,0xBB,0xCC,0xDD -> word 0xDDCCBBAA at addr 0, buffer 0. overflow=0 and rd_buffer=1.
- Random out_ready (50%) over 2 frames at the maximum input rate -> no overflow, and every address from 0..29999 appears exactly once per buffer, in order.
